// File: rtl/wbsdram_arb.sv
// wbsdram_arb: multi-port Wishbone B4 pipelined front end for the SDRAM controller.
// Arbitrates NPORT Wishbone slave ports onto one generic request/response bus and
// routes in-order read responses back to the issuing port via a port-ID FIFO.
//
// Ports:
//   clk, rst                     single clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i          per-port Wishbone control (NPORT bits each)
//   wb_adr_i/dat_i/sel_i         per-port address/write data/byte select, port p at [p*W +: W]
//   wb_dat_o/ack_o/stall_o       per-port read data, ack, stall
//   req_valid/write/addr/wdata/byteenable, req_ready   request to the controller
//   rsp_valid/rsp_rdata          in-order read data from the controller
//   err_orphan                   sticky: response arrived with no read outstanding
module wbsdram_arb #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned AW        = 24,
  parameter int unsigned DW        = 16,
  parameter int unsigned RDQ_DEPTH = 4,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      wb_cyc_i,
  input  logic [NPORT-1:0]      wb_stb_i,
  input  logic [NPORT-1:0]      wb_we_i,
  input  logic [NPORT*AW-1:0]   wb_adr_i,
  input  logic [NPORT*DW-1:0]   wb_dat_i,
  input  logic [NPORT*DW/8-1:0] wb_sel_i,
  output logic [NPORT*DW-1:0]   wb_dat_o,
  output logic [NPORT-1:0]      wb_ack_o,
  output logic [NPORT-1:0]      wb_stall_o,
  output logic                  req_valid,
  output logic                  req_write,
  output logic [AW-1:0]         req_addr,
  output logic [DW-1:0]         req_wdata,
  output logic [DW/8-1:0]       req_byteenable,
  input  logic                  req_ready,
  input  logic                  rsp_valid,
  input  logic [DW-1:0]         rsp_rdata,
  output logic                  err_orphan
);

  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned QW = $clog2(RDQ_DEPTH);
  localparam int unsigned CW = $clog2(RDQ_DEPTH + 1);
  localparam int unsigned BW = DW / 8;

  logic [NPORT-1:0] req, elig, grant;
  logic [PW-1:0]    gidx, head;
  logic             accept, push, pop, fifo_full, fifo_empty;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    fifo_q [RDQ_DEPTH];
  logic [PW-1:0]    fifo_d [RDQ_DEPTH];
  logic [QW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]    rd_cnt_q [NPORT];
  logic [CW-1:0]    rd_cnt_d [NPORT];
  logic [NPORT-1:0] ack_q, ack_d;
  logic [DW-1:0]    dat_q [NPORT];
  logic [DW-1:0]    dat_d [NPORT];
  logic             err_q, err_d;

  assign fifo_full  = (fifo_cnt_q == CW'(RDQ_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Reads need FIFO room (a same-cycle pop does not count); writes wait until
  // the port has no reads in flight so its acks stay ordered.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      req[p]  = wb_cyc_i[p] & wb_stb_i[p];
      elig[p] = req[p] & ~rst & (wb_we_i[p] ? (rd_cnt_q[p] == '0) : ~fifo_full);
    end
  end

  always_comb begin : grant_sel
    int unsigned idx_full;
    logic [PW-1:0] idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (PRIO_MODE == 1) begin
        idx_full = i;
      end else begin
        idx_full = 32'(rr_ptr_q) + i;
        if (idx_full >= NPORT) idx_full = idx_full - NPORT;
      end
      idx = PW'(idx_full);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  // One-hot OR mux of the granted port's payload.
  always_comb begin
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_byteenable = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (grant[p]) begin
        req_write      = req_write | wb_we_i[p];
        req_addr       = req_addr | wb_adr_i[p*AW +: AW];
        req_wdata      = req_wdata | wb_dat_i[p*DW +: DW];
        req_byteenable = req_byteenable | wb_sel_i[p*BW +: BW];
      end
    end
  end

  assign req_valid  = |grant;
  assign accept     = req_valid & req_ready;
  assign wb_stall_o = ~(grant & {NPORT{req_ready}});
  assign push       = accept & ~req_write;
  assign pop        = rsp_valid & ~fifo_empty;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gidx == PW'(NPORT - 1)) ? '0 : gidx + PW'(1);

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = gidx;
    wr_ptr_d = push ? wr_ptr_q + QW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + QW'(1) : rd_ptr_q;

    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    for (int p = 0; p < NPORT; p++) begin
      logic inc, dec;
      inc         = push && (gidx == PW'(p));
      dec         = pop && (head == PW'(p));
      rd_cnt_d[p] = rd_cnt_q[p];
      if (inc && !dec)      rd_cnt_d[p] = rd_cnt_q[p] + CW'(1);
      else if (dec && !inc) rd_cnt_d[p] = rd_cnt_q[p] - CW'(1);
    end

    // A write ack and a read ack never share a port: writes need rd_cnt == 0.
    ack_d = '0;
    if (accept && req_write) ack_d[gidx] = 1'b1;
    dat_d = dat_q;
    if (pop) begin
      ack_d[head] = wb_cyc_i[head];  // suppressed if the master abandoned the cycle
      dat_d[head] = rsp_rdata;
    end

    err_d = err_q | (rsp_valid & fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < RDQ_DEPTH; i++) fifo_q[i] <= '0;
      for (int p = 0; p < NPORT; p++) begin
        rd_cnt_q[p] <= '0;
        dat_q[p]    <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      for (int i = 0; i < RDQ_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      for (int p = 0; p < NPORT; p++) begin
        rd_cnt_q[p] <= rd_cnt_d[p];
        dat_q[p]    <= dat_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) wb_dat_o[p*DW +: DW] = dat_q[p];
  end

  assign wb_ack_o   = ack_q;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_wbsdram_arb.sv
module tb_wbsdram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [47:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;

  logic [31:0] dat_o, f_dat_o;
  logic [1:0]  ack, stall, f_ack, f_stall;
  logic        req_valid, req_write, f_req_valid, f_req_write;
  logic [23:0] req_addr, f_req_addr;
  logic [15:0] req_wdata, f_req_wdata;
  logic [1:0]  req_be, f_req_be;
  logic        err, f_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wbsdram_arb #(.NPORT(2), .AW(24), .DW(16), .RDQ_DEPTH(4), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_stall_o(stall),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byteenable(req_be), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err_orphan(err)
  );

  wbsdram_arb #(.NPORT(2), .AW(24), .DW(16), .RDQ_DEPTH(4), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(f_dat_o), .wb_ack_o(f_ack),
    .wb_stall_o(f_stall), .req_valid(f_req_valid), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_byteenable(f_req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err_orphan(f_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
    rsp_valid = 1'b0; rsp_rdata = '0; req_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc = 2'b11; stb = 2'b11; we = 2'b11; req_ready = 1'b1;
    tick();
    #1;
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
    n_vec++; if (f_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_fp_req_valid got %b want 0", f_req_valid); end
    n_vec++; if (stall !== 2'b11) begin n_err++; $display("FAIL rst_stall got %b want 11", stall); end
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL rst_ack got %b want 00", ack); end
    n_vec++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat got %h want 0", dat_o); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[23:0] = 24'h000010; wdat[15:0] = 16'hA5A5; sel[1:0] = 2'b11;
    #1;
    n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL wr_req_valid got %b want 1", req_valid); end
    n_vec++; if (req_write !== 1'b1) begin n_err++; $display("FAIL wr_req_write got %b want 1", req_write); end
    n_vec++; if (req_addr !== 24'h000010) begin n_err++; $display("FAIL wr_addr got %h want 000010", req_addr); end
    n_vec++; if (req_wdata !== 16'hA5A5) begin n_err++; $display("FAIL wr_wdata got %h want a5a5", req_wdata); end
    n_vec++; if (req_be !== 2'b11) begin n_err++; $display("FAIL wr_be got %b want 11", req_be); end
    n_vec++; if (stall !== 2'b10) begin n_err++; $display("FAIL wr_stall got %b want 10", stall); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (ack !== 2'b01) begin n_err++; $display("FAIL wr_ack got %b want 01", ack); end
    tick();
    #1;
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL wr_ack_clear got %b want 00", ack); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc = 2'b11; stb = 2'b11; we = 2'b11;
    adr = {24'h000200, 24'h000100}; wdat = {16'h2222, 16'h1111}; sel = 4'hF;
    for (int c = 0; c < 6; c++) begin
      logic [1:0] exp_stall, exp_ack;
      logic [23:0] exp_addr;
      #1;
      exp_stall = (c % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr  = (c % 2 == 0) ? 24'h000100 : 24'h000200;
      n_vec++; if (stall !== exp_stall) begin n_err++; $display("FAIL rr_stall c=%0d got %b want %b", c, stall, exp_stall); end
      n_vec++; if (req_addr !== exp_addr) begin n_err++; $display("FAIL rr_addr c=%0d got %h want %h", c, req_addr, exp_addr); end
      n_vec++; if (f_stall !== 2'b10) begin n_err++; $display("FAIL fp_stall c=%0d got %b want 10", c, f_stall); end
      if (c > 0) begin
        exp_ack = (c % 2 == 1) ? 2'b01 : 2'b10;
        n_vec++; if (ack !== exp_ack) begin n_err++; $display("FAIL rr_ack c=%0d got %b want %b", c, ack, exp_ack); end
        n_vec++; if (f_ack !== 2'b01) begin n_err++; $display("FAIL fp_ack c=%0d got %b want 01", c, f_ack); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_read_depth();
    do_reset();
    cyc[0] = 1'b1; we[0] = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      logic exp_stall, exp_ack;
      stb[0]     = (c <= 11);
      adr[23:0]  = 24'((c < 4) ? c : 4);
      rsp_valid  = (c >= 10 && c <= 14);
      rsp_rdata  = 16'(c - 9);
      #1;
      exp_stall = !(c < 4 || c == 11);
      exp_ack   = (c >= 11 && c <= 15);
      n_vec++; if (stall[0] !== exp_stall) begin n_err++; $display("FAIL rdq_stall c=%0d got %b want %b", c, stall[0], exp_stall); end
      n_vec++; if (ack[0] !== exp_ack) begin n_err++; $display("FAIL rdq_ack c=%0d got %b want %b", c, ack[0], exp_ack); end
      if (exp_ack) begin
        n_vec++; if (dat_o[15:0] !== 16'(c - 10)) begin n_err++; $display("FAIL rdq_dat c=%0d got %h want %h", c, dat_o[15:0], 16'(c - 10)); end
      end
      if (!exp_stall) begin
        n_vec++; if (req_addr !== 24'((c < 4) ? c : 4)) begin n_err++; $display("FAIL rdq_addr c=%0d got %h", c, req_addr); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_read_then_write();
    do_reset();
    cyc = 2'b01; stb = 2'b01; we = 2'b00; adr[23:0] = 24'h000040;
    #1;
    n_vec++; if (stall !== 2'b10) begin n_err++; $display("FAIL rw_rd_stall got %b want 10", stall); end
    tick();
    cyc = 2'b11; stb = 2'b11; we = 2'b11; adr = {24'h000080, 24'h000041};
    #1;
    n_vec++; if (stall !== 2'b01) begin n_err++; $display("FAIL rw_hold_stall got %b want 01", stall); end
    n_vec++; if (req_addr !== 24'h000080) begin n_err++; $display("FAIL rw_p1_addr got %h want 000080", req_addr); end
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0; rsp_valid = 1'b1; rsp_rdata = 16'hBEEF;
    #1;
    n_vec++; if (ack !== 2'b10) begin n_err++; $display("FAIL rw_p1_ack got %b want 10", ack); end
    n_vec++; if (stall[0] !== 1'b1) begin n_err++; $display("FAIL rw_p0_wait got %b want 1", stall[0]); end
    tick();
    rsp_valid = 1'b0;
    #1;
    n_vec++; if (ack !== 2'b01) begin n_err++; $display("FAIL rw_rd_ack got %b want 01", ack); end
    n_vec++; if (dat_o[15:0] !== 16'hBEEF) begin n_err++; $display("FAIL rw_rd_dat got %h want beef", dat_o[15:0]); end
    n_vec++; if (stall !== 2'b10) begin n_err++; $display("FAIL rw_p0_wr_stall got %b want 10", stall); end
    n_vec++; if (req_addr !== 24'h000041) begin n_err++; $display("FAIL rw_p0_addr got %h want 000041", req_addr); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (ack !== 2'b01) begin n_err++; $display("FAIL rw_wr_ack got %b want 01", ack); end
    tick();
  endtask

  task automatic test_interleave();
    logic [1:0]  stb_v [4];
    logic [1:0]  st_v  [4];
    logic [15:0] rsp_v [7];
    logic [1:0]  ack_v [7];
    stb_v = '{2'b10, 2'b01, 2'b10, 2'b00};
    st_v  = '{2'b01, 2'b10, 2'b01, 2'b11};
    rsp_v = '{16'h0, 16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    ack_v = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
    do_reset();
    cyc = 2'b11; we = 2'b00; adr = {24'h000400, 24'h000300};
    for (int c = 0; c < 7; c++) begin
      stb       = (c < 4) ? stb_v[c] : 2'b00;
      rsp_valid = (rsp_v[c] != 16'h0);
      rsp_rdata = rsp_v[c];
      #1;
      if (c < 4) begin
        n_vec++; if (stall !== st_v[c]) begin n_err++; $display("FAIL il_stall c=%0d got %b want %b", c, stall, st_v[c]); end
      end
      n_vec++; if (ack !== ack_v[c]) begin n_err++; $display("FAIL il_ack c=%0d got %b want %b", c, ack, ack_v[c]); end
      tick();
    end
    // Read data registers hold the last value delivered to each port.
    n_vec++; if (dat_o !== {16'h3333, 16'h2222}) begin n_err++; $display("FAIL il_dat got %h want 33332222", dat_o); end
    idle_inputs();
  endtask

  task automatic test_orphan();
    do_reset();
    rsp_valid = 1'b1; rsp_rdata = 16'hDEAD;
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL orph_pre got %b want 0", err); end
    tick();
    rsp_valid = 1'b0;
    #1;
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL orph_ack got %b want 00", ack); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL orph_set got %b want 1", err); end
    tick();
    tick();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL orph_sticky got %b want 1", err); end
    // Two reads in flight, then reset mid-operation.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL mrst_req_valid got %b want 0", req_valid); end
    n_vec++; if (stall !== 2'b11) begin n_err++; $display("FAIL mrst_stall got %b want 11", stall); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mrst_err got %b want 0", err); end
    tick();
    rst = 1'b0;
    we[0] = 1'b1;
    #1;
    n_vec++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL mrst_rdcnt got %b want 0", stall[0]); end
    tick();
    idle_inputs();
    rsp_valid = 1'b1; rsp_rdata = 16'h0BAD;
    #1;
    n_vec++; if (ack !== 2'b01) begin n_err++; $display("FAIL mrst_wr_ack got %b want 01", ack); end
    tick();
    rsp_valid = 1'b0;
    #1;
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL mrst_orph_ack got %b want 00", ack); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mrst_orph_err got %b want 1", err); end
    tick();
  endtask

  task automatic test_abandon();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
    tick();
    cyc = '0; stb = '0;
    tick();
    rsp_valid = 1'b1; rsp_rdata = 16'h5A5A;
    tick();
    rsp_valid = 1'b0;
    #1;
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL abn_ack got %b want 00", ack); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL abn_err got %b want 0", err); end
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    #1;
    n_vec++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL abn_rdcnt got %b want 0", stall[0]); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_depth();
    test_read_then_write();
    test_interleave();
    test_orphan();
    test_abandon();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
